sva_result_monitor: RTL
=======================

// Module: sva_result_monitor
// PURPOSE
//  Consumes the per-attempt result pulses (succ/fail/lazy_succ) of an SVA FSM checker on sys_clk.
//  Keeps saturating result counters, timestamps failures in gclk cycles, and buffers them in a small log FIFO.
//  Issues an end-of-test verdict once the checker has drained.
//  Sits directly downstream of the checker; the log is read by the testbench/file-dump stage.
// PARAMETERS
//  CNT_WIDTH   16  width of succ/fail/lazy counters (saturating)
//  TS_WIDTH    16  width of gclk-cycle timestamp (wraps)
//  LOG_DEPTH   8   failure-log entries; power of 2, >=2
//  FAIL_LIMIT  1   fail count at which fail_limit_hit sets; >=1
// PORTS
//  sys_clk            in   1          system clock, the only clock
//  sys_rst            in   1          synchronous active-high reset
//  start              in   1          pulse: clear stats, begin monitoring
//  end_of_test        in   1          pulse: stop accepting after drain
//  gclk_posedge_flag  in   1          one-sys_clk pulse per user-clock rising edge
//  chk_busy           in   1          checker still evaluating
//  res_valid          in   1          qualifies succ/fail/lazy_succ for this cycle
//  succ/fail/lazy_succ in  1 each     checker result levels
//  succ_cnt/fail_cnt/lazy_cnt out CNT_WIDTH  result counters
//  fail_limit_hit     out  1          sticky: fail_cnt >= FAIL_LIMIT
//  log_valid          out  1          log head entry available
//  log_ready          in   1          consumer pops head when log_valid&&log_ready
//  log_ts             out  TS_WIDTH   gclk timestamp of head failure
//  log_overflow       out  1          sticky: a failure was dropped (log full)
//  verdict            out  2          verdict_t: NONE=0 PASS=1 FAIL=2 VACUOUS=3
//  verdict_valid      out  1          high in DONE
// BEHAVIOUR
//  - Reset: FSM=IDLE; all counters, ts, flags, FIFO pointers = 0; verdict=NONE; verdict_valid=0; log_valid=0.
//  - FSM: IDLE -start-> RUN; RUN -end_of_test-> DRAIN; DRAIN -(!chk_busy)-> DONE; DONE -start-> RUN.
//    start in RUN/DRAIN restarts (clears stats and log) and enters RUN. start has priority over end_of_test.
//  - start cycle: counters, ts, fail_limit_hit, log_overflow and FIFO are cleared. Results in that cycle are ignored.
//  - ts: increments (wraps) on gclk_posedge_flag in RUN/DRAIN; frozen in IDLE/DONE.
//  - Accept results only when res_valid && state in {RUN, DRAIN}. Each asserted flag bumps its own counter in the same cycle.
//    Counters saturate at all-ones. Simultaneous flags are all counted.
//  - Counter outputs are registered: value visible 1 cycle after the accepted res_valid.
//  - fail_limit_hit sets when the next fail_cnt value reaches FAIL_LIMIT; cleared only by start/reset.
//  - Log push: accepted fail with the current ts (the pre-increment ts if gclk_posedge_flag coincides).
//    Full and no pop: entry dropped, log_overflow<=1. Full with a pop in the same cycle: push accepted.
//    Pop when empty: ignored.
//  - Log is first-word-fall-through: an entry pushed in cycle N gives log_valid=1 in N+1.
//    log_ts is stable while log_valid && !log_ready.
//  - DONE entry: verdict = FAIL if fail_cnt>0; else PASS if succ_cnt+lazy_cnt>0; else VACUOUS.
//    The verdict is latched and held until start or reset. Log remains readable in DONE.
//  - end_of_test in IDLE/DONE: ignored. Results in IDLE/DONE: ignored (not counted).
// STRUCTURE
//  - Package sva_mon_pkg:
//    - verdict_t (2-bit enum)
//    - mon_state_t {IDLE, RUN, DRAIN, DONE}
//    - log_entry_t (packed struct holding ts)
//  - Sub-module sva_log_fifo: sync FWFT FIFO, parameters WIDTH and DEPTH.
//    Ports: push, pop, din, dout, empty, full, clr. Pointer wrap uses an extra MSB.
//  - Top holds the FSM, counters, ts and verdict logic.
// TESTING
//  1 reset, start, 3x res_valid&succ, end_of_test, chk_busy=0
//    -> succ_cnt=3, fail_cnt=0, verdict=PASS, verdict_valid=1 by 2 cycles after end_of_test.
//  2 start, 5 gclk flags, res_valid&fail
//    -> fail_cnt=1, fail_limit_hit=1, log entry ts=5; verdict=FAIL after end/drain.
//  3 LOG_DEPTH=8: 10 fails with log_ready=0
//    -> 8 entries, log_overflow=1, fail_cnt=10; pop 8 in order; log_valid=0 after.
//  4 end_of_test with chk_busy=1 for 4 cycles, fail during drain
//    -> stays DRAIN, fail counted, verdict=FAIL once busy drops.
//  5 start, no results, end_of_test -> verdict=VACUOUS; then start -> counters 0, verdict=NONE, RUN.
//  6 CNT_WIDTH=4: 20 succ -> succ_cnt=15 (saturated); res_valid in IDLE -> no count.

Source files
------------

// File: rtl/sva_mon_pkg.sv
// Shared types for the SVA result monitor: verdict encoding, FSM states and log entry layout.
package sva_mon_pkg;

   typedef enum logic [1:0] {
      VERDICT_NONE    = 2'd0,
      VERDICT_PASS    = 2'd1,
      VERDICT_FAIL    = 2'd2,
      VERDICT_VACUOUS = 2'd3
   } verdict_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } mon_state_t;

   localparam int unsigned LOG_TS_WIDTH = 16;

   typedef struct packed {
      logic [LOG_TS_WIDTH-1:0] ts;
   } log_entry_t;

   // Any failure dominates; otherwise at least one success means PASS.
   function automatic verdict_t calc_verdict(input logic any_fail, input logic any_pass);
      if (any_fail)      return VERDICT_FAIL;
      else if (any_pass) return VERDICT_PASS;
      else               return VERDICT_VACUOUS;
   endfunction

endpackage

// File: rtl/sva_log_fifo.sv
// Synchronous first-word-fall-through FIFO holding failure timestamps.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module sva_log_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sva_result_monitor.sv
// Counts SVA checker results, timestamps failures into a log FIFO and issues an end-of-test verdict.
module sva_result_monitor
   import sva_mon_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned TS_WIDTH   = LOG_TS_WIDTH,
   parameter int unsigned LOG_DEPTH  = 8,
   parameter int unsigned FAIL_LIMIT = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic                 end_of_test,
   input  logic                 gclk_posedge_flag,
   input  logic                 chk_busy,
   input  logic                 res_valid,
   input  logic                 succ,
   input  logic                 fail,
   input  logic                 lazy_succ,
   output logic [CNT_WIDTH-1:0] succ_cnt,
   output logic [CNT_WIDTH-1:0] fail_cnt,
   output logic [CNT_WIDTH-1:0] lazy_cnt,
   output logic                 fail_limit_hit,
   output logic                 log_valid,
   input  logic                 log_ready,
   output logic [TS_WIDTH-1:0]  log_ts,
   output logic                 log_overflow,
   output verdict_t             verdict,
   output logic                 verdict_valid
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
   localparam logic [CNT_WIDTH-1:0] FAIL_LIMIT_C = CNT_WIDTH'(FAIL_LIMIT);

   mon_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] succ_cnt_q, succ_cnt_d;
   logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
   logic [CNT_WIDTH-1:0] lazy_cnt_q, lazy_cnt_d;
   logic [TS_WIDTH-1:0]  ts_q, ts_d;
   logic                 fail_limit_hit_q, fail_limit_hit_d;
   logic                 log_overflow_q, log_overflow_d;
   verdict_t             verdict_q, verdict_d;
   logic                 active, accept, log_push, log_pop, log_empty, log_full;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
      return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
   endfunction

   assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign accept   = res_valid && active && !start;
   assign log_push = accept && fail;
   assign log_pop  = log_ready && !log_empty;

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:   if (end_of_test) state_d = ST_DRAIN;
            ST_DRAIN: if (!chk_busy)   state_d = ST_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      succ_cnt_d       = sat_inc(succ_cnt_q, accept && succ);
      fail_cnt_d       = sat_inc(fail_cnt_q, accept && fail);
      lazy_cnt_d       = sat_inc(lazy_cnt_q, accept && lazy_succ);
      ts_d             = (active && gclk_posedge_flag) ? ts_q + 1'b1 : ts_q;
      fail_limit_hit_d = fail_limit_hit_q || (fail_cnt_d >= FAIL_LIMIT_C);
      log_overflow_d   = log_overflow_q || (log_push && log_full && !log_pop);
      verdict_d        = verdict_q;
      // Verdict uses next-state counts so a result accepted on the last DRAIN cycle is included.
      if (state_q == ST_DRAIN && state_d == ST_DONE)
         verdict_d = calc_verdict(fail_cnt_d != '0, (succ_cnt_d != '0) || (lazy_cnt_d != '0));
      if (start) begin
         succ_cnt_d       = '0;
         fail_cnt_d       = '0;
         lazy_cnt_d       = '0;
         ts_d             = '0;
         fail_limit_hit_d = 1'b0;
         log_overflow_d   = 1'b0;
         verdict_d        = VERDICT_NONE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q          <= ST_IDLE;
         succ_cnt_q       <= '0;
         fail_cnt_q       <= '0;
         lazy_cnt_q       <= '0;
         ts_q             <= '0;
         fail_limit_hit_q <= 1'b0;
         log_overflow_q   <= 1'b0;
         verdict_q        <= VERDICT_NONE;
      end else begin
         state_q          <= state_d;
         succ_cnt_q       <= succ_cnt_d;
         fail_cnt_q       <= fail_cnt_d;
         lazy_cnt_q       <= lazy_cnt_d;
         ts_q             <= ts_d;
         fail_limit_hit_q <= fail_limit_hit_d;
         log_overflow_q   <= log_overflow_d;
         verdict_q        <= verdict_d;
      end
   end

   sva_log_fifo #(
      .WIDTH (TS_WIDTH),
      .DEPTH (LOG_DEPTH)
   ) u_log_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (start),
      .push  (log_push),
      .pop   (log_pop),
      .din   (ts_q),
      .dout  (log_ts),
      .empty (log_empty),
      .full  (log_full)
   );

   assign succ_cnt       = succ_cnt_q;
   assign fail_cnt       = fail_cnt_q;
   assign lazy_cnt       = lazy_cnt_q;
   assign fail_limit_hit = fail_limit_hit_q;
   assign log_overflow   = log_overflow_q;
   assign log_valid      = !log_empty;
   assign verdict        = verdict_q;
   assign verdict_valid  = (state_q == ST_DONE);

endmodule
